azimuth_signal_recorder: RTL and testbench

Captures one azimuth frame of the serial target-video line into a SIZE-bit vector, one bit per CLK, starting at a TRIG rising edge. It is the receive-side counterpart of the azimuth signal generator: the generator replays a stored bit vector onto SIGNAL after each trigger, and this block rebuilds that vector from SIGNAL. It is used for loopback self-test and for recording live radar video into the DMA path. Each completed frame is presented as a held DATA word plus a one-cycle VALID strobe.

---
 rtl/azimuth_signal_recorder.sv | 132 +++++++++++++
 tb/tb_azimuth_signal_recorder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/azimuth_signal_recorder.sv
// Azimuth signal recorder: rebuilds one SIZE-bit frame from the serial
// video line after each trigger edge and presents it with a VALID strobe.
module azimuth_signal_recorder #(
    parameter int SIZE  = 3200,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             TRIG,
    input  logic             SIGNAL,
    output logic [SIZE-1:0]  DATA,
    output logic             VALID,
    output logic             BUSY,
    output logic [CNT_W-1:0] CNT,
    output logic [15:0]      FRAMES,
    output logic             OVERRUN
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic              trig_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SIZE-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [SIZE-1:0]   data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       frames_q, frames_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              trig_rise;
    logic [SIZE-1:0]   shift_in;
    logic [CNT_W-1:0]  run_in;

    assign trig_rise = TRIG & ~trig_q;
    // Newest sample enters at the MSB, so bit 0 ends up holding the first.
    // Stale bits from an earlier frame are flushed out by SIZE new samples.
    assign shift_in  = {SIGNAL, shift_q[SIZE-1:1]};
    assign run_in    = run_q + CNT_W'(SIGNAL);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        run_d     = run_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        frames_d  = frames_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (EN && trig_rise) begin
                    state_d = CAPTURE;
                    shift_d = shift_in;
                    idx_d   = IDX_W'(1);
                    run_d   = CNT_W'(SIGNAL);
                end
            end
            CAPTURE: begin
                shift_d = shift_in;
                if (!EN) begin
                    state_d = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    data_d   = shift_in;
                    cnt_d    = run_in;
                    frames_d = frames_q + 16'd1;
                    valid_d  = 1'b1;
                    // A trigger on the completion edge chains straight into
                    // the next frame without counting as an overrun.
                    if (trig_rise) begin
                        idx_d = IDX_W'(1);
                        run_d = CNT_W'(SIGNAL);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trig_rise) begin
                    idx_d     = IDX_W'(1);
                    run_d     = CNT_W'(SIGNAL);
                    overrun_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    run_d = run_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            idx_q     <= '0;
            shift_q   <= '0;
            run_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            frames_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= TRIG;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            run_q     <= run_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            frames_q  <= frames_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q == CAPTURE);
    assign CNT     = cnt_q;
    assign FRAMES  = frames_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_azimuth_signal_recorder.sv
// Directed bench for azimuth_signal_recorder at SIZE=8.
module tb_azimuth_signal_recorder;

    localparam int SIZE  = 8;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             trig;
    logic             sig;
    logic [SIZE-1:0]  data;
    logic             valid;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      frames;
    logic             overrun;

    int n_pass  = 0;
    int n_total = 0;

    azimuth_signal_recorder #(.SIZE(SIZE)) dut (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en),
        .TRIG   (trig),
        .SIGNAL (sig),
        .DATA   (data),
        .VALID  (valid),
        .BUSY   (busy),
        .CNT    (cnt),
        .FRAMES (frames),
        .OVERRUN(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply inputs, take one edge, settle 1 time unit past it.
    task automatic step(input logic s, input logic t);
        sig  = s;
        trig = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] p;
        rst = 1'b1; en = 1'b0; trig = 1'b0; sig = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_data",    32'(data), 32'h0);
        chk("rst_valid",   32'(valid), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_cnt",     32'(cnt), 32'h0);
        chk("rst_frames",  32'(frames), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // Trigger with EN low is ignored.
        step(1'b1, 1'b1);
        chk("en0_trig_busy", 32'(busy), 32'h0);
        step(1'b0, 1'b0);
        en = 1'b1;

        // Basic frame: samples 1,0,1,1,0,0,0,1 -> 8'h8D.
        p = 8'h8D;
        for (int i = 0; i < 8; i++) begin
            step(p[i], i == 0);
            if (i < 7) begin
                chk("f1_busy", 32'(busy), 32'h1);
                chk("f1_novalid", 32'(valid), 32'h0);
            end
        end
        chk("f1_valid",  32'(valid), 32'h1);
        chk("f1_busy_end", 32'(busy), 32'h0);
        chk("f1_data",   32'(data), 32'h8D);
        chk("f1_cnt",    32'(cnt), 32'd4);
        chk("f1_frames", 32'(frames), 32'd1);
        step(1'b0, 1'b0);
        chk("f1_valid_drop", 32'(valid), 32'h0);

        // Abort: EN dropped at E0+5.
        for (int i = 0; i < 5; i++) step(1'b1, i == 0);
        en = 1'b0;
        step(1'b1, 1'b0);
        chk("ab_busy",   32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            chk("ab_novalid", 32'(valid), 32'h0);
        end
        chk("ab_data",   32'(data), 32'h8D);
        chk("ab_cnt",    32'(cnt), 32'd4);
        chk("ab_frames", 32'(frames), 32'd1);
        chk("ab_overrun", 32'(overrun), 32'h0);
        en = 1'b1;
        p = 8'h3E;
        for (int i = 0; i < 8; i++) step(p[i], i == 0);
        chk("ab2_valid",  32'(valid), 32'h1);
        chk("ab2_data",   32'(data), 32'h3E);
        chk("ab2_cnt",    32'(cnt), 32'd5);
        chk("ab2_frames", 32'(frames), 32'd2);

        // Retrigger at E0+3 with SIGNAL all ones.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rt_overrun", 32'(overrun), 32'h1);
        chk("rt_busy",    32'(busy), 32'h1);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b1);
            if (i < 7) chk("rt_novalid", 32'(valid), 32'h0);
        end
        chk("rt_valid",  32'(valid), 32'h1);
        chk("rt_data",   32'(data), 32'hFF);
        chk("rt_cnt",    32'(cnt), 32'd8);
        chk("rt_frames", 32'(frames), 32'd1);
        step(1'b0, 1'b0);

        // Retrigger on the completion edge: 0x81 then 0x55 sharing E0+7.
        do_reset();
        p = 8'h81;
        for (int i = 0; i < 8; i++) step(p[i], i == 0 || i == 7);
        chk("bb_valid1",  32'(valid), 32'h1);
        chk("bb_data1",   32'(data), 32'h81);
        chk("bb_cnt1",    32'(cnt), 32'd2);
        chk("bb_busy",    32'(busy), 32'h1);
        chk("bb_overrun1", 32'(overrun), 32'h0);
        p = 8'h55;
        for (int i = 1; i < 8; i++) begin
            step(p[i], 1'b1);
            if (i < 7) chk("bb_novalid", 32'(valid), 32'h0);
        end
        chk("bb_valid2",   32'(valid), 32'h1);
        chk("bb_data2",    32'(data), 32'h55);
        chk("bb_cnt2",     32'(cnt), 32'd4);
        chk("bb_frames",   32'(frames), 32'd2);
        chk("bb_overrun2", 32'(overrun), 32'h0);
        // TRIG held high: no further frames.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        chk("hold_busy",   32'(busy), 32'h0);
        chk("hold_frames", 32'(frames), 32'd2);
        step(1'b0, 1'b0);

        // RST mid-capture at E0+4.
        for (int i = 0; i < 4; i++) step(1'b1, i == 0);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        chk("mr_data",   32'(data), 32'h0);
        chk("mr_busy",   32'(busy), 32'h0);
        chk("mr_cnt",    32'(cnt), 32'h0);
        chk("mr_frames", 32'(frames), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            chk("mr_novalid", 32'(valid), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
